// File: rtl/scanline_fetch.sv
// scanline_fetch: PSRAM bus master that fills a two-bank line buffer one source line ahead
// and scans it out 2x/2x scaled. Define SCANLINE_DIM_EN to halve colour on odd display rows.
module scanline_fetch #(
  parameter int          LINE_PIXELS = 320,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter logic [23:0] BASE_ADDR   = 24'h000000
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic [8:0]  i_scan_row,
  input  logic [9:0]  i_scan_column,
  input  logic        i_blank,
  input  logic        i_enable,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [23:0] o_mem_addr,
  input  logic        i_mem_busy,
  input  logic        i_mem_done,
  input  logic [15:0] i_mem_data,
  output logic [11:0] o_color,
  output logic        o_busy,
  output logic        o_underrun
);
  localparam int IDX_W     = $clog2(LINE_PIXELS);
  localparam int RAM_DEPTH = 2 * LINE_PIXELS;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         line_q, line_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pend_q, pend_d;
  logic [7:0]         pend_line_q, pend_line_d;
  logic               stb_q, stb_d;
  logic [23:0]        addr_q, addr_d;
  logic               underrun_q, underrun_d;
  logic [11:0]        color_q;
  logic               wr_en;
  logic               ram_we;

  logic [7:0]         src_line;
  logic [8:0]         src_x;
  logic               at_hblank;
  logic               row_fetch;
  logic               row_last;
  logic               trig;
  logic [7:0]         trig_line;
  logic [23:0]        word_off;
  logic [23:0]        req_addr;
  logic [RAM_AW-1:0]  wr_addr;
  logic [RAM_AW-1:0]  rd_addr;
  logic               unused_bits;

  logic [11:0] line_ram [0:RAM_DEPTH-1];

  assign src_line  = i_scan_row[8:1];
  assign src_x     = i_scan_column[9:1];
  assign at_hblank = (i_scan_column == 10'(H_ACTIVE));
  assign row_fetch = !i_scan_row[0] && (i_scan_row < 9'(V_ACTIVE - 2));
  assign row_last  = (i_scan_row == 9'(V_ACTIVE - 1));
  assign trig      = i_enable && at_hblank && (row_fetch || row_last);
  assign trig_line = row_last ? 8'd0 : src_line + 8'd1;

  assign word_off  = 24'(line_q) * 24'(LINE_PIXELS) + 24'(idx_q);
  assign req_addr  = BASE_ADDR + {word_off[22:0], 1'b0};

  assign unused_bits = ^{i_mem_data[15:12], i_scan_column[0]};

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_line_d = pend_line_q;
    stb_d       = 1'b0;
    addr_d      = addr_q;
    underrun_d  = underrun_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_REQ;
          line_d  = trig_line;
          idx_d   = '0;
        end
      end
      ST_REQ: begin
        // Nothing is outstanding here, so an overrun restarts on the new line at once.
        if (trig) begin
          underrun_d = 1'b1;
          line_d     = trig_line;
          idx_d      = '0;
        end else if (!i_mem_busy) begin
          stb_d   = 1'b1;
          addr_d  = req_addr;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (trig) begin
          underrun_d  = 1'b1;
          pend_d      = 1'b1;
          pend_line_d = trig_line;
        end
        if (i_mem_done) begin
          wr_en = 1'b1;
          if (trig || pend_q) begin
            state_d = ST_REQ;
            line_d  = trig ? trig_line : pend_line_q;
            idx_d   = '0;
            pend_d  = 1'b0;
          end else if (idx_q == IDX_W'(LINE_PIXELS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_line_q <= '0;
      stb_q       <= 1'b0;
      addr_q      <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_line_q <= pend_line_d;
      stb_q       <= stb_d;
      addr_q      <= addr_d;
      underrun_q  <= underrun_d;
    end
  end

  // Bank select is the source line's LSB; the read side clamps off-screen columns.
  assign ram_we  = wr_en && !i_rst;
  assign wr_addr = line_q[0] ? RAM_AW'(LINE_PIXELS) + RAM_AW'(idx_q) : RAM_AW'(idx_q);
  assign rd_addr = (src_x >= 9'(LINE_PIXELS)) ? '0 :
                   (src_line[0] ? RAM_AW'(LINE_PIXELS) + RAM_AW'(src_x) : RAM_AW'(src_x));

  always_ff @(posedge i_pix_clk) begin
    if (ram_we) begin
      line_ram[wr_addr] <= i_mem_data[11:0];
    end
    if (i_rst || i_blank) begin
      color_q <= '0;
    end else begin
      color_q <= line_ram[rd_addr];
    end
  end

`ifdef SCANLINE_DIM_EN
  logic dim_q;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      dim_q <= 1'b0;
    end else begin
      dim_q <= i_scan_row[0];
    end
  end

  assign o_color = dim_q ? {1'b0, color_q[11:9], 1'b0, color_q[7:5], 1'b0, color_q[3:1]}
                         : color_q;
`else
  assign o_color = color_q;
`endif

  assign o_mem_stb  = stb_q;
  assign o_mem_we   = 1'b0;
  assign o_mem_addr = addr_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_scanline_fetch.sv
// Randomised self-checking bench for scanline_fetch: PSRAM model with configurable latency
// and a per-bank reference image built from the pixel pattern of each completed line fetch.
`timescale 1ns/1ps
module tb_scanline_fetch;
  localparam int LP = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  scan_row = '0;
  logic [9:0]  scan_col = 10'd700;
  logic        blank = 1'b1;
  logic        enable = 1'b1;
  logic        mem_stb, mem_we, mem_busy, mem_done;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic [11:0] color;
  logic        busy, underrun;

  always #5 clk = ~clk;

  scanline_fetch dut (
    .i_pix_clk(clk), .i_rst(rst), .i_scan_row(scan_row), .i_scan_column(scan_col),
    .i_blank(blank), .i_enable(enable), .o_mem_stb(mem_stb), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .i_mem_busy(mem_busy), .i_mem_done(mem_done),
    .i_mem_data(mem_data), .o_color(color), .o_busy(busy), .o_underrun(underrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Source image: word n of the bitmap carries pixel ((n*pat_mul) ^ pat_xor).
  int pat_mul = 1;
  int pat_xor = 0;
  function automatic logic [11:0] pix(input int n);
    return 12'((n * pat_mul) ^ pat_xor);
  endfunction

  // PSRAM model: one outstanding read, done 'lat' clocks after the strobe.
  int          lat = 3;
  bit          outstanding = 1'b0;
  int          cnt = 0;
  logic [23:0] pend_addr = '0;
  logic [23:0] last_addr = '0;
  logic        model_done = 1'b0;
  logic [15:0] model_data = '0;
  logic        inj_done = 1'b0;
  logic        force_busy = 1'b0;
  bit          busy_prev = 1'b0;
  int          stb_count = 0, done_count = 0, proto_bad = 0, addr_bad = 0;
  int          trig_epoch = 0, seen_epoch = 0, exp_line = 0, exp_idx = 0;

  assign mem_busy = force_busy | outstanding;
  assign mem_done = model_done | inj_done;
  assign mem_data = inj_done ? 16'hFFFF : model_data;

  always @(posedge clk) begin : psram_model
    int idx_now;
    model_done <= 1'b0;
    busy_prev  <= mem_busy;
    if (outstanding) begin
      if (cnt <= 1) begin
        model_done  <= 1'b1;
        model_data  <= {4'($urandom_range(0, 15)), pix(int'(pend_addr >> 1))};
        outstanding <= 1'b0;
        done_count  <= done_count + 1;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (mem_stb === 1'b1) begin
      if (trig_epoch != seen_epoch) begin
        idx_now = 0;
        seen_epoch <= trig_epoch;
      end else begin
        idx_now = exp_idx;
      end
      if (busy_prev || outstanding) proto_bad <= proto_bad + 1;
      if (mem_addr !== 24'(2 * (exp_line * LP + idx_now))) addr_bad <= addr_bad + 1;
      exp_idx     <= idx_now + 1;
      stb_count   <= stb_count + 1;
      last_addr   <= mem_addr;
      pend_addr   <= mem_addr;
      outstanding <= 1'b1;
      cnt         <= lat - 1;
    end
  end

  // Reference image of the two line banks as they should look after each finished fetch.
  logic [11:0] ref_ram [2][LP];
  bit          ref_valid [2] = '{1'b0, 1'b0};

  function automatic logic [11:0] shade(input int row, input logic [11:0] c);
`ifdef SCANLINE_DIM_EN
    if (row % 2 == 1) begin
      logic [3:0] r, g, b;
      r = c[11:8] >> 1;
      g = c[7:4] >> 1;
      b = c[3:0] >> 1;
      return {r, g, b};
    end
`endif
    return c;
  endfunction

  task automatic check_pix(input int row, input int col, input bit bl, input string tag,
                           output logic [11:0] got);
    logic [11:0] exp;
    @(negedge clk);
    scan_row = 9'(row);
    scan_col = 10'(col);
    blank    = bl;
    @(posedge clk);
    #1;
    got = color;
    exp = bl ? 12'h000 : shade(row, ref_ram[(row / 2) % 2][col / 2]);
    chk($sformatf("%s_r%0d_c%0d", tag, row, col), 32'(got), 32'(exp));
  endtask

  task automatic rand_pix(input int n, input string tag);
    logic [11:0] got;
    for (int i = 0; i < n; i++) begin
      int row, col;
      bit bl;
      do row = $urandom_range(0, 479); while (!ref_valid[(row / 2) % 2]);
      if ($urandom_range(0, 3) == 0) begin
        col = $urandom_range(641, 799);
        bl  = 1'b1;
      end else begin
        col = $urandom_range(0, 639);
        bl  = ($urandom_range(0, 7) == 0);
      end
      check_pix(row, col, bl, tag, got);
    end
  endtask

  function automatic int line_of(input int row);
    return (row == 479) ? 0 : row / 2 + 1;
  endfunction

  // One hblank trigger cycle; 'valid' says whether the row should start a fetch.
  task automatic trigger(input int row, input bit valid, input string tag);
    @(negedge clk);
    scan_row = 9'(row);
    scan_col = 10'd640;
    blank    = 1'b1;
    @(posedge clk);
    #1;
    if (valid) begin
      exp_line = line_of(row);
      trig_epoch++;
    end
    chk({tag, "_busy_after_trig"}, 32'(busy), 32'(valid));
    @(negedge clk);
    scan_col = 10'd700;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 6000);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic fill_ref(input int line);
    for (int i = 0; i < LP; i++) ref_ram[line % 2][i] = pix(line * LP + i);
    ref_valid[line % 2] = 1'b1;
  endtask

  task automatic do_fetch(input int row, input string tag);
    int s0, d0, a0, p0;
    s0 = stb_count; d0 = done_count; a0 = addr_bad; p0 = proto_bad;
    trigger(row, 1'b1, tag);
    wait_idle(tag);
    @(posedge clk);
    #1;
    chk({tag, "_stb_count"}, 32'(stb_count - s0), 32'(LP));
    chk({tag, "_done_count"}, 32'(done_count - d0), 32'(LP));
    chk({tag, "_addr_seq"}, 32'(addr_bad - a0), 32'd0);
    chk({tag, "_protocol"}, 32'(proto_bad - p0), 32'd0);
    fill_ref(line_of(row));
    $display("fetch %s: row=%0d line=%0d words=%0d last_addr=%06h", tag, row,
             line_of(row), stb_count - s0, last_addr);
  endtask

  initial begin
    logic [11:0] got;
    int s0, n, row;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_stb", 32'(mem_stb), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Frame prefetch of line 0, then first pixels
    do_fetch(479, "t1");
    check_pix(0, 0, 1'b0, "t1", got);
    chk("t1_r0c0_const", 32'(got), 32'h000);
    check_pix(0, 2, 1'b0, "t1", got);
    chk("t1_r0c2_const", 32'(got), 32'h001);

    // Line 1 into bank 1
    do_fetch(0, "t2");
    chk("t2_last_addr", 32'(last_addr), 32'h0004FE);
    check_pix(2, 638, 1'b0, "t2", got);
    chk("t2_r2c638_const", 32'(got), 32'h27F);
    rand_pix(16, "t2_rand");

    // Rows that must not start a fetch
    s0 = stb_count;
    trigger(1, 1'b0, "odd_row");
    trigger(478, 1'b0, "row478");
    enable = 1'b0;
    trigger(0, 1'b0, "disabled");
    enable = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_trig_stb", 32'(stb_count - s0), 32'd0);

    // Random patterns on random even rows
    for (int k = 0; k < 3; k++) begin
      pat_mul = int'($urandom_range(1, 4095));
      pat_xor = int'($urandom_range(0, 4095));
      row = 2 * int'($urandom_range(0, 238));
      do_fetch(row, $sformatf("rnd%0d", k));
      rand_pix(12, $sformatf("rnd%0d_pix", k));
    end

    // Bus held busy after a trigger
    force_busy = 1'b1;
    s0 = stb_count;
    trigger(10, 1'b1, "t3");
    repeat (20) @(posedge clk);
    #1;
    chk("t3_no_stb_while_busy", 32'(stb_count - s0), 32'd0);
    @(negedge clk);
    force_busy = 1'b0;
    wait_idle("t3");
    @(posedge clk);
    #1;
    chk("t3_stb_count", 32'(stb_count - s0), 32'(LP));
    chk("t3_stb_eq_done", 32'(stb_count), 32'(done_count));
    chk("t3_protocol", 32'(proto_bad), 32'd0);
    fill_ref(6);

    // Solid colour for the dim check
    pat_mul = 0;
    pat_xor = 12'hFA8;
    do_fetch(479, "t6");
    check_pix(0, 100, 1'b0, "t6", got);
    chk("t6_even_const", 32'(got), 32'hFA8);
    check_pix(1, 100, 1'b0, "t6", got);
`ifdef SCANLINE_DIM_EN
    chk("t6_odd_const", 32'(got), 32'h754);
`else
    chk("t6_odd_const", 32'(got), 32'hFA8);
`endif

    // Slow PSRAM: the fetch overruns its two-row budget
    pat_mul = 3;
    pat_xor = 12'h5A5;
    lat = 8;
    trigger(0, 1'b1, "t4a");
    repeat (1600) @(posedge clk);
    #1;
    chk("t4_still_busy", 32'(busy), 32'd1);
    chk("t4_no_underrun_yet", 32'(underrun), 32'd0);
    trigger(2, 1'b1, "t4b");
    chk("t4_underrun_set", 32'(underrun), 32'd1);
    s0 = stb_count;
    n = 0;
    while (stb_count == s0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_restart_addr", 32'(last_addr), 32'h000500);
    wait_idle("t4");
    @(posedge clk);
    #1;
    chk("t4_underrun_sticky", 32'(underrun), 32'd1);
    chk("t4_stb_eq_done", 32'(stb_count), 32'(done_count));
    chk("t4_addr_seq", 32'(addr_bad), 32'd0);
    chk("t4_protocol", 32'(proto_bad), 32'd0);
    fill_ref(2);
    ref_valid[1] = 1'b0;
    rand_pix(10, "t4_pix");
    $display("overrun: underrun=%0d last_addr=%06h", underrun, last_addr);
    lat = 3;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_underrun_cleared", 32'(underrun), 32'd0);

    // Reset while waiting for a word; late done pulses must not write
    pat_mul = 7;
    pat_xor = 12'h123;
    trigger(479, 1'b1, "t5");
    n = 0;
    while (mem_stb !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_stb_seen", 32'(mem_stb), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s0 = stb_count;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_stb", 32'(mem_stb), 32'd0);
    chk("t5_no_new_stb", 32'(stb_count - s0), 32'd0);
    check_pix(0, 0, 1'b0, "t5_keep", got);
    check_pix(1, 1, 1'b0, "t5_keep", got);
    $display("reset-in-wait: busy=%0d color=%03h", busy, got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
